sq_iter_sched: RTL

Iteration scheduler for the redundant-Montgomery modular squarer. It accepts a job: start/final iteration count, checkpoint interval and initial value. It loads and starts the squarer, counts its completion pulses, emits intermediate checkpoints and the final result over a ready/valid port, and handles abort and hang detection. It sits between the host-facing AXI stream unpacker and `redun_wrapper`, replacing ad-hoc sequencing logic.

---
 rtl/sq_iter_sched_if.sv | 40 ++++
 rtl/sq_iter_sched.sv | 90 +++++++++
 2 files changed

// File: rtl/sq_iter_sched_if.sv
// sq_iter_sched_if: job config, squarer control and result handshake bundle for sq_iter_sched.
interface sq_iter_sched_if #(
    parameter int T_LEN    = 64,
    parameter int SQ_BITS  = 128,
    parameter int CKPT_LEN = 32
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [T_LEN-1:0]    cfg_t_start;
    logic [T_LEN-1:0]    cfg_t_final;
    logic [CKPT_LEN-1:0] cfg_ckpt_interval;
    logic [SQ_BITS-1:0]  cfg_sq_in;
    logic                abort;
    logic                sq_reset;
    logic                sq_start;
    logic [SQ_BITS-1:0]  sq_in;
    logic                sq_valid;
    logic [SQ_BITS-1:0]  sq_out;
    logic                res_valid;
    logic                res_ready;
    logic [T_LEN-1:0]    res_t;
    logic [SQ_BITS-1:0]  res_sq;
    logic [1:0]          res_status;
    logic [15:0]         drop_count;
    logic                busy;

    modport master (
        output cfg_valid, cfg_t_start, cfg_t_final, cfg_ckpt_interval, cfg_sq_in, abort,
               sq_valid, sq_out, res_ready,
        input  cfg_ready, sq_reset, sq_start, sq_in, res_valid, res_t, res_sq, res_status,
               drop_count, busy
    );

    modport slave (
        input  cfg_valid, cfg_t_start, cfg_t_final, cfg_ckpt_interval, cfg_sq_in, abort,
               sq_valid, sq_out, res_ready,
        output cfg_ready, sq_reset, sq_start, sq_in, res_valid, res_t, res_sq, res_status,
               drop_count, busy
    );
endinterface

// File: rtl/sq_iter_sched.sv
// sq_iter_sched: sequences the modular squarer for a job, posting checkpoints and a terminal result.
module sq_iter_sched #(
    parameter int T_LEN       = 64,
    parameter int SQ_BITS     = 128,
    parameter int CKPT_LEN    = 32,
    parameter int WDOG_CYCLES = 4096
) (
    input logic           clk,
    input logic           reset_n,
    sq_iter_sched_if.slave bus
);
    localparam int WW = WDOG_CYCLES > 0 ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES > 0 ? WDOG_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_t;

    state_t              state;
    logic [T_LEN-1:0]    t_cur, t_fin, t_nx, t_post;
    logic [CKPT_LEN-1:0] ival, ckpt, ckpt_nx;
    logic [SQ_BITS-1:0]  last, last_post;
    logic [WW-1:0]       wdog;
    logic                step, fin, ld_fin, ab, tout, hard, ckp, stall, drop;
    logic [1:0]          st_hard;

    assign step    = state == RUN && bus.sq_valid;
    assign t_nx    = t_cur + 1'b1;
    assign ckpt_nx = ckpt + 1'b1;
    assign fin     = step && t_nx == t_fin;
    assign ld_fin  = state == LOAD && t_cur == t_fin;
    assign ab      = bus.abort && (state == LOAD || state == START || state == RUN);
    assign tout    = WDOG_CYCLES != 0 && state == RUN && !bus.sq_valid && wdog == WDOG_LAST;
    assign hard    = fin || ld_fin || ab || tout;
    assign ckp     = step && ival != '0 && ckpt_nx == ival && !hard;
    assign stall   = bus.res_valid && !bus.res_ready;
    assign drop    = stall && (ckp || (hard && bus.res_status == 2'd0));
    assign st_hard = (fin || ld_fin) ? 2'd1 : ab ? 2'd2 : 2'd3;
    // Every result reports the post-update position; last tracks sq_in until the first sq_valid.
    assign t_post    = step ? t_nx : t_cur;
    assign last_post = step ? bus.sq_out : last;

    assign bus.cfg_ready = state == IDLE;
    assign bus.busy      = state != IDLE;
    assign bus.sq_reset  = state == IDLE || state == DONE;
    assign bus.sq_start  = state == START;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            bus.res_valid  <= 1'b0;
            bus.res_status <= 2'd0;
            bus.res_t      <= '0;
            bus.res_sq     <= '0;
            bus.drop_count <= '0;
        end else begin
            state <= hard ? DONE :
                     (state == IDLE && bus.cfg_valid) ? LOAD :
                     state == LOAD ? START :
                     state == START ? RUN :
                     (state == DONE && bus.res_valid && bus.res_ready) ? IDLE : state;
            if (hard || (ckp && !stall)) begin
                bus.res_valid  <= 1'b1;
                bus.res_t      <= t_post;
                bus.res_sq     <= last_post;
                bus.res_status <= hard ? st_hard : 2'd0;
            end else if (bus.res_ready) begin
                bus.res_valid <= 1'b0;
            end
            if (drop && bus.drop_count != 16'hFFFF)
                bus.drop_count <= bus.drop_count + 16'd1;
            if (state == IDLE && bus.cfg_valid)
                bus.drop_count <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && bus.cfg_valid) begin
            t_cur      <= bus.cfg_t_start;
            t_fin      <= bus.cfg_t_final;
            ival       <= bus.cfg_ckpt_interval;
            ckpt       <= '0;
            last       <= bus.cfg_sq_in;
            bus.sq_in  <= bus.cfg_sq_in;
        end else if (step) begin
            t_cur <= t_nx;
            last  <= bus.sq_out;
            ckpt  <= ckpt_nx == ival ? '0 : ckpt_nx;
        end
        wdog <= (state == RUN && !bus.sq_valid) ? wdog + 1'b1 : '0;
    end
endmodule
